// File: rtl/tmr_sched.sv
// Multi-channel millisecond alarm scheduler: one shared decrementer is swept
// across NCH channel down-counters once per timer tick, with a word-addressed register file.
module tmr_sched #(
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        stb,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        irq
);

    // state  | meaning
    // S_IDLE | waiting for a tick (or a tick queued during the last scan)
    // S_SCAN | stepping channel idx, one channel per cycle

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;

    logic [CW-1:0]   count  [NCH];
    logic [CW-1:0]   reload [NCH];
    logic [NCH-1:0]  enable, periodic, pending, mask;
    logic            overrun, tick_pend;

    logic [NCH-1:0]  wr_ch, step, fire;
    logic            wr, wr_ctl, wr_stat, wr_mask, ov_set;
    logic            unused_bits;

    assign wr      = stb & we;
    assign wr_ctl  = wr && (addr == 4'd8);
    assign wr_stat = wr && (addr == 4'd9);
    assign wr_mask = wr && (addr == 4'd10);
    assign ack     = stb;
    assign unused_bits = ^data_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE: begin
                if (tick || tick_pend) begin
                    state_nxt = S_SCAN;
                    idx_nxt   = '0;
                end
            end
            S_SCAN: begin
                if (idx == IW'(NCH - 1)) begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // A bus write to the channel being stepped takes precedence and drops the step.
    always_comb begin
        wr_ch  = '0;
        step   = '0;
        fire   = '0;
        ov_set = (state == S_SCAN) && tick && tick_pend;
        for (int i = 0; i < NCH; i++) begin
            wr_ch[i] = wr && (addr == 4'(i));
            step[i]  = (state == S_SCAN) && (idx == IW'(i)) && enable[i]
                       && (count[i] != '0) && !wr_ch[i];
            fire[i]  = step[i] && (count[i] == CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                count[i]  <= '0;
                reload[i] <= '0;
            end
            enable    <= '0;
            periodic  <= '0;
            pending   <= '0;
            mask      <= '0;
            overrun   <= 1'b0;
            tick_pend <= 1'b0;
            irq       <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_ch[i]) begin
                    count[i]  <= data_in[CW-1:0];
                    reload[i] <= data_in[CW-1:0];
                end else if (fire[i]) begin
                    count[i] <= periodic[i] ? reload[i] : '0;
                end else if (step[i]) begin
                    count[i] <= count[i] - CW'(1);
                end
            end

            // One-shot expiry clears its enable even against a concurrent control write.
            enable <= (wr_ctl ? data_in[NCH-1:0] : enable) & ~(fire & ~periodic);
            if (wr_ctl)
                periodic <= data_in[8 +: NCH];
            if (wr_mask)
                mask <= data_in[NCH-1:0];

            pending <= fire | (pending & ~(wr_stat ? data_in[NCH-1:0] : '0));
            overrun <= ov_set | (overrun & ~(wr_stat & data_in[16]));

            if (state == S_SCAN) begin
                if (tick)
                    tick_pend <= 1'b1;
            end else if (tick_pend) begin
                tick_pend <= tick;
            end

            irq <= |(pending & mask);
        end
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < NCH; i++) begin
            if (addr == 4'(i))
                data_out = 32'(count[i]);
        end
        case (addr)
            4'd8: begin
                data_out[NCH-1:0]  = enable;
                data_out[8 +: NCH] = periodic;
            end
            4'd9: begin
                data_out[NCH-1:0] = pending;
                data_out[16]      = overrun;
            end
            4'd10: data_out[NCH-1:0] = mask;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tmr_sched.sv
// Scoreboard bench for tmr_sched: stimulus queues expected read/irq values,
// a negedge monitor pops and compares them whenever a read or irq probe is presented.
module tb_tmr_sched;

    localparam int NCH = 4;
    localparam int CW  = 16;

    logic        clk = 1'b0;
    logic        rst_n, tick, stb, we, ack, irq;
    logic [3:0]  addr;
    logic [31:0] data_in, data_out;

    always #5 clk = ~clk;

    tmr_sched #(.NCH(NCH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .stb(stb), .we(we),
        .addr(addr), .data_in(data_in), .data_out(data_out),
        .ack(ack), .irq(irq)
    );

    typedef struct {
        bit          kind;   // 0: bus read, 1: irq sample
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_bad = 0;
    logic probe = 1'b0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        stb = 1'b1; we = 1'b1; addr = a; data_in = d;
        step(1);
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
        exp_t x;
        x.kind = 1'b0; x.exp = e; x.name = nm;
        sb_q.push_back(x);
        stb = 1'b1; we = 1'b0; addr = a;
        step(1);
        stb = 1'b0;
    endtask

    task automatic chk_irq(input logic e, input string nm);
        exp_t x;
        x.kind = 1'b1; x.exp = {31'b0, e}; x.name = nm;
        sb_q.push_back(x);
        probe = 1'b1;
        step(1);
        probe = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(NCH + 1);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        if ((stb && !we) || probe) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: output presented with nothing expected");
            end else begin
                e = sb_q.pop_front();
                act = e.kind ? {31'b0, irq} : data_out;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, act, e.exp, $time);
                end
                if (!e.kind) begin
                    n_chk++;
                    if (ack !== 1'b1) begin
                        n_bad++;
                        $display("FAIL ack: got %b expected 1 at %0t", ack, $time);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; tick = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; data_in = '0;
        step(3);
        rst_n = 1'b1;

        for (int a = 0; a < 16; a++) rd(4'(a), 32'h0, "rst_rd");
        chk_irq(1'b0, "rst_irq");

        // one-shot on ch0
        wr(4'd0, 32'd3); wr(4'd8, 32'h1); wr(4'd10, 32'h1);
        rd(4'd0, 32'd3, "os_cnt0");
        do_tick(); rd(4'd0, 32'd2, "os_cnt1");
        do_tick(); rd(4'd0, 32'd1, "os_cnt2");
        tick = 1'b1; step(1); tick = 1'b0;
        chk_irq(1'b0, "os_irq_pre");
        chk_irq(1'b0, "os_irq_lag");
        chk_irq(1'b1, "os_irq_set");
        step(2);
        rd(4'd0, 32'd0, "os_cnt3");
        rd(4'd9, 32'h1, "os_pend");
        rd(4'd8, 32'h0, "os_en_clr");
        wr(4'd9, 32'h1);
        chk_irq(1'b1, "os_irq_hold");
        chk_irq(1'b0, "os_irq_clr");
        rd(4'd9, 32'h0, "os_pend_clr");

        // periodic on ch1
        wr(4'd1, 32'd2); wr(4'd8, 32'h0202);
        rd(4'd8, 32'h0202, "per_ctl");
        rd(4'd1, 32'd2, "per_cnt0");
        for (int k = 1; k <= 6; k++) begin
            do_tick();
            rd(4'd1, (k % 2 == 1) ? 32'd1 : 32'd2, "per_cnt");
            rd(4'd9, (k % 2 == 1) ? 32'h0 : 32'h2, "per_pend");
            if (k % 2 == 0) wr(4'd9, 32'h2);
        end
        chk_irq(1'b0, "per_irq_masked");
        wr(4'd8, 32'h0);

        // tick during scan, then overrun
        for (int c = 0; c < NCH; c++) wr(4'(c), 32'd10);
        wr(4'd8, 32'hF);
        tick = 1'b1; step(1); tick = 1'b0; step(1); tick = 1'b1; step(1); tick = 1'b0;
        step(12);
        for (int c = 0; c < NCH; c++) rd(4'(c), 32'd8, "pend_cnt");
        rd(4'd9, 32'h0, "pend_no_ovr");
        tick = 1'b1; step(1); tick = 1'b0; step(1); tick = 1'b1; step(2); tick = 1'b0;
        step(12);
        for (int c = 0; c < NCH; c++) rd(4'(c), 32'd6, "ovr_cnt");
        rd(4'd9, 32'h10000, "ovr_set");
        wr(4'd9, 32'h10000);
        rd(4'd9, 32'h0, "ovr_clr");

        // bus write collides with step of ch2
        wr(4'd2, 32'd5);
        tick = 1'b1; step(1); tick = 1'b0; step(2);
        wr(4'd2, 32'd9);
        step(3);
        rd(4'd2, 32'd9, "col_cnt2");
        rd(4'd0, 32'd5, "col_cnt0");
        rd(4'd9, 32'h0, "col_pend");

        // pending set and W1C in the same cycle
        wr(4'd2, 32'd1);
        tick = 1'b1; step(1); tick = 1'b0; step(2);
        wr(4'd9, 32'h4);
        step(3);
        rd(4'd9, 32'h4, "w1c_set_wins");
        rd(4'd8, 32'hB, "w1c_en");
        rd(4'd2, 32'd0, "w1c_cnt2");
        rd(4'd3, 32'd4, "w1c_cnt3");
        wr(4'd9, 32'h4);
        rd(4'd9, 32'h0, "w1c_clr");

        // reset while idx=2
        wr(4'd10, 32'hF);
        tick = 1'b1; step(1); tick = 1'b0; step(2);
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        for (int a = 0; a <= 10; a++) rd(4'(a), 32'h0, "mid_rst_rd");
        chk_irq(1'b0, "mid_rst_irq");
        wr(4'd0, 32'd2); wr(4'd8, 32'h1);
        step(10);
        rd(4'd0, 32'd2, "mid_rst_noscan");

        // disabled and zero-count channels
        wr(4'd0, 32'd4); wr(4'd3, 32'd0); wr(4'd8, 32'h8); wr(4'd10, 32'hF);
        repeat (10) do_tick();
        rd(4'd0, 32'd4, "dis_cnt0");
        rd(4'd3, 32'd0, "zero_cnt3");
        rd(4'd9, 32'h0, "dis_pend");
        rd(4'd8, 32'h8, "zero_en");
        chk_irq(1'b0, "dis_irq");

        // truncation and unused address
        wr(4'd1, 32'h0001_0007);
        rd(4'd1, 32'd7, "trunc");
        wr(4'd12, 32'hFFFF_FFFF);
        rd(4'd12, 32'h0, "unused_addr");

        step(2);
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/tmr_sched.md
Name: tmr_sched

Overview:
- Multi-channel millisecond alarm scheduler driven by the 1 ms tick of the system millisecond timer.
- One shared decrementer is time-multiplexed over NCH channel down-counters by a scan state machine. The scan runs once per tick.
- Channels raise pending flags that merge into one level interrupt to the RISC5 core.
- Sits on the I/O bus next to the timer, with a word-addressed register file.

Parameters:
- NCH, 4, number of alarm channels (1..8).
- CW, 16, channel counter width in bits (1..32).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- tick  in  1  one-cycle pulse per millisecond from the timer
- stb  in  1  bus strobe, this device selected
- we  in  1  write enable, qualified by stb
- addr  in  4  word address
- data_in  in  32  write data
- data_out  out  32  read data, combinational from addr
- ack  out  1  equals stb (single-cycle access)
- irq  out  1  registered interrupt request

Behaviour:
- Reset (rst_n=0 at clk edge): all counts, reloads, enable, periodic, pending, mask and overrun are 0; FSM is IDLE; irq=0. data_out reads 0 for every address.
- Register map (unused bits read 0, unused addresses read 0 and ignore writes):
  - addr 0..NCH-1: channel i. A write sets reload[i]=count[i]=data_in[CW-1:0]. A read returns the current count[i] zero-extended.
  - addr 8: control. Bits [7:0] are enable, bits [15:8] are periodic; only the low NCH bits of each field exist. Read/write.
  - addr 9: status. Bits [7:0] are pending, bit 16 is overrun. Writing 1 clears a bit; writing 0 has no effect.
  - addr 10: irq mask, bits [7:0]. Read/write.
- FSM states: IDLE and SCAN, plus a channel index idx of width clog2(NCH), minimum 1.
  - IDLE: if tick=1 or tick_pend=1, go to SCAN with idx=0 and clear tick_pend.
  - SCAN: process channel idx each cycle, then idx+1. After idx=NCH-1, return to IDLE. A full scan takes exactly NCH cycles.
- Channel step, only if enable[idx]=1 and count[idx]!=0:
  - If count==1: count becomes 0 and pending[idx] is set.
    - If periodic[idx]=1, count is reloaded from reload[idx].
    - Otherwise enable[idx] is cleared.
  - Else count is decremented by 1.
  - An enabled channel with count 0 is left untouched and never fires.
- Tick while SCAN, or in the same cycle the scan starts from tick_pend: tick_pend is set. If tick_pend was already 1, overrun is set (sticky) and the extra tick is lost.
- Simultaneous events:
  - Bus write to channel i in the same cycle the scan steps channel i: the bus write wins and the step for i is dropped for that tick.
  - Write to control in the same cycle a one-shot clears enable[i]: the step's clear of enable[i] wins over the written value. Other bits take the written value.
  - W1C of pending[i] or overrun in the same cycle it is set: set wins.
- irq is registered: irq <= |(pending & mask). It is therefore 1 cycle after the pending or mask change, and stays high until the bits are cleared or masked.
- Reset mid-scan: FSM returns to IDLE, tick_pend=0, and all state is cleared; no partial-scan effects survive.
- Arithmetic: counts are unsigned CW-bit values. A written value wider than CW is truncated to CW bits. No wrap-around is possible, since decrement only occurs from a nonzero count.

Test Plan:
- One-shot: write ch0=3, control=0x0001, mask=0x01, then 3 ticks → after the third scan, count0=0, pending=0x01, enable bit0=0, irq=1 one cycle later. Write status=0x01 → irq=0.
- Periodic: write ch1=2, control=0x0202, then 6 ticks → pending[1] is set on ticks 2, 4 and 6 (W1C-clear between ticks). Reads of ch1 go 2,1,2,1,2,1,2.
- Tick during scan (NCH=4): tick at cycle t, second tick at t+2 → the second scan starts right after the first ends and all counters decrement twice. A third tick at t+3 → overrun (status bit 16) =1.
- Collision: scan steps ch2 (count=5) in the same cycle as a bus write ch2=9 → count2=9 after that cycle and pending2 stays unchanged. Set and W1C of pending2 in the same cycle → pending2=1.
- Reset mid-scan: rst_n=0 for 1 cycle while idx=2 → all registers read 0, irq=0, and no further scan until the next tick.
- Disabled and zero channels: enable=1 with ch3=0, plus ch0=4 with enable=0, then 10 ticks → counts unchanged, pending=0, irq=0.
